key_event_fsm: RTL and testbench

KEY_EVENT_FSM -- requirements
Module: key_event_fsm

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_event_fifo.sv | 42 ++++
 rtl/key_event_fsm.sv | 81 ++++++++
 tb/tb_key_event_fsm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared scan-code constants, event kinds and prefix states for the keyboard event path
package key_pkg;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  typedef enum logic [1:0] {KIND_CHAR, KIND_ENTER, KIND_BKSP} kind_t;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} pstate_t;
  typedef struct packed {
    kind_t       kind;
    logic        upper;
    logic        ext;
    logic [7:0]  code;
  } event_t;
  function automatic kind_t kind_of(input logic [7:0] code);
    return code == SC_ENTER ? KIND_ENTER : code == SC_BKSP ? KIND_BKSP : KIND_CHAR;
  endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: event queue with sticky overflow; a full queue still accepts a push when popping in the same cycle
module key_event_fifo import key_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop_req,
  input  logic   clr,
  input  event_t din,
  output logic   valid,
  output event_t dout,
  output logic   overflow
);
  localparam int AW = $clog2(DEPTH);
  event_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic full, pop, wr_en;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    valid = count != '0;
    pop = pop_req && valid;
    wr_en = push && (!full || pop);
    dout = valid ? mem[rd] : '0;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow <= (push && !wr_en) || (overflow && !clr);
    end
  end
endmodule

// File: rtl/key_event_fsm.sv
// key_event_fsm: decodes scan-code bytes into queued key events, tracking shift, caps lock and typematic repeats
module key_event_fsm import key_pkg::*; #(
  parameter int DEPTH = 4,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       doneKey,
  input  logic [7:0] keyData,
  input  logic       evReady,
  output logic       evValid,
  output logic [7:0] evCode,
  output logic       evExt,
  output logic       evUpper,
  output logic [1:0] evKind,
  output logic       capsLock,
  output logic       shiftHeld,
  output logic       overflow,
  input  logic       clrOverflow
);
  pstate_t st;
  logic caps_held, lshift, rshift, last_vld;
  logic [8:0] last_key;
  logic brk, ext, decode, modifier, rep, push;
  event_t ev_in, ev_out;
  always_comb begin
    brk = st == BRK || st == EXT_BRK;
    ext = st == EXT || st == EXT_BRK;
    decode = doneKey && !(st == IDLE && (keyData == SC_BRK || keyData == SC_EXT))
                     && !(st == EXT && keyData == SC_BRK) && !(st == BRK && keyData == SC_EXT);
    modifier = keyData == SC_LSHIFT || keyData == SC_RSHIFT || keyData == SC_CAPS;
    rep = REPEAT_FILTER && last_vld && last_key == {ext, keyData};
    push = decode && !brk && !modifier && !rep;
    ev_in = '{kind: kind_of(keyData), upper: capsLock ^ shiftHeld, ext: ext, code: keyData};
  end
  assign shiftHeld = lshift | rshift;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      capsLock <= 1'b0;
      caps_held <= 1'b0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (doneKey) begin
      st <= st == IDLE && keyData == SC_BRK ? BRK :
            st == IDLE && keyData == SC_EXT ? EXT :
            st == EXT && keyData == SC_BRK ? EXT_BRK : IDLE;
      if (decode) begin
        if (!ext && keyData == SC_LSHIFT) lshift <= !brk;
        if (!ext && keyData == SC_RSHIFT) rshift <= !brk;
        if (keyData == SC_CAPS) begin
          caps_held <= !brk;
          if (!brk && !caps_held) capsLock <= !capsLock;
        end
        // any break re-arms the repeat filter
        if (brk) last_vld <= 1'b0;
        else if (push) begin
          last_vld <= 1'b1;
          last_key <= {ext, keyData};
        end
      end
    end
  end
  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop_req(evReady),
    .clr(clrOverflow),
    .din(ev_in),
    .valid(evValid),
    .dout(ev_out),
    .overflow(overflow)
  );
  assign evCode = ev_out.code;
  assign evExt = ev_out.ext;
  assign evUpper = ev_out.upper;
  assign evKind = ev_out.kind;
endmodule

// File: tb/tb_key_event_fsm.sv
// tb_key_event_fsm: directed scan-code sequences against hand-computed key events
module tb_key_event_fsm;
  logic clk = 1'b0, rst = 1'b1, doneKey = 1'b0, evReady = 1'b0, clrOverflow = 1'b0;
  logic [7:0] keyData = '0;
  logic evValid, evExt, evUpper, capsLock, shiftHeld, overflow;
  logic [7:0] evCode;
  logic [1:0] evKind;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  key_event_fsm #(.DEPTH(4), .REPEAT_FILTER(1'b1)) dut (
    .clk(clk), .rst(rst), .doneKey(doneKey), .keyData(keyData), .evReady(evReady),
    .evValid(evValid), .evCode(evCode), .evExt(evExt), .evUpper(evUpper), .evKind(evKind),
    .capsLock(capsLock), .shiftHeld(shiftHeld), .overflow(overflow), .clrOverflow(clrOverflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    doneKey = 1'b1;
    keyData = b;
    @(negedge clk);
    doneKey = 1'b0;
    keyData = '0;
  endtask
  task automatic send_seq(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask
  task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext, input logic upper, input logic [1:0] kind);
    check({tag, ".valid"}, 32'(evValid), 32'd1);
    check({tag, ".code"}, 32'(evCode), 32'(code));
    check({tag, ".ext"}, 32'(evExt), 32'(ext));
    check({tag, ".upper"}, 32'(evUpper), 32'(upper));
    check({tag, ".kind"}, 32'(evKind), 32'(kind));
    evReady = 1'b1;
    @(negedge clk);
    evReady = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    // reset: doneKey ignored, all outputs low
    @(negedge clk);
    doneKey = 1'b1;
    keyData = 8'h1C;
    @(negedge clk);
    check("rst.valid", 32'(evValid), 0);
    check("rst.outs", {evCode, evExt, evUpper, evKind, capsLock, shiftHeld, overflow}, 0);
    doneKey = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst.after", 32'(evValid), 0);
    // make, break -> single char event
    send(8'h1C);
    check("t37.lat", 32'(evValid), 1);
    send_seq('{8'hF0, 8'h1C});
    expect_ev("t37", 8'h1C, 0, 0, 0);
    check("t37.empty", 32'(evValid), 0);
    // shift affects case of the first 1C only
    do_reset();
    send(8'h12);
    check("t38.shift_on", 32'(shiftHeld), 1);
    send(8'h1C);
    send_seq('{8'hF0, 8'h12});
    check("t38.shift_off", 32'(shiftHeld), 0);
    send(8'h1C);
    expect_ev("t38a", 8'h1C, 0, 1, 0);
    expect_ev("t38b", 8'h1C, 0, 0, 0);
    check("t38.empty", 32'(evValid), 0);
    // caps lock auto-repeat toggles once
    do_reset();
    send_seq('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58});
    check("t39.caps", 32'(capsLock), 1);
    check("t39.noev", 32'(evValid), 0);
    send(8'h1C);
    expect_ev("t39", 8'h1C, 0, 1, 0);
    // extended enter, extended break
    do_reset();
    send_seq('{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A});
    expect_ev("t40", 8'h5A, 1, 0, 1);
    check("t40.empty", 32'(evValid), 0);
    send(8'h66);
    expect_ev("bksp", 8'h66, 0, 0, 2);
    // typematic repeats filtered
    send_seq('{8'h1C, 8'h1C, 8'h1C});
    expect_ev("rep", 8'h1C, 0, 0, 0);
    check("rep.empty", 32'(evValid), 0);
    // overflow with full FIFO
    do_reset();
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D});
    check("t41.no_ovf", 32'(overflow), 0);
    send(8'h2C);
    check("t41.ovf", 32'(overflow), 1);
    @(negedge clk);
    clrOverflow = 1'b1;
    doneKey = 1'b1;
    keyData = 8'h3C;
    @(negedge clk);
    clrOverflow = 1'b0;
    doneKey = 1'b0;
    check("set_wins", 32'(overflow), 1);
    // full + pop + push in the same cycle
    doneKey = 1'b1;
    keyData = 8'h35;
    evReady = 1'b1;
    @(negedge clk);
    doneKey = 1'b0;
    evReady = 1'b0;
    expect_ev("t41a", 8'h1D, 0, 0, 0);
    expect_ev("t41b", 8'h24, 0, 0, 0);
    expect_ev("t41c", 8'h2D, 0, 0, 0);
    expect_ev("t41d", 8'h35, 0, 0, 0);
    check("t41.empty", 32'(evValid), 0);
    evReady = 1'b1;
    @(negedge clk);
    evReady = 1'b0;
    check("pop_empty", 32'(evValid), 0);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    // reset clears a pending break prefix and a queued event
    send(8'h21);
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.valid", 32'(evValid), 0);
    check("rst_mid.code", 32'(evCode), 0);
    rst = 1'b0;
    send(8'h1C);
    expect_ev("t42", 8'h1C, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
